// File: rtl/cell_test_sequencer_if.sv
// Vector stream into the cell test sequencer: one test vector per valid/ready handshake.
// Handshake: a vector transfers on a rising clk edge where vec_valid and vec_ready are both 1; the source holds fields stable while vec_valid is high.
interface cell_test_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                      vec_valid;
  logic                      vec_ready;
  logic [DATA_WIDTH-1:0]     vec_inp;
  logic [DATA_WIDTH-1:0]     vec_par;
  logic [2*DATA_WIDTH-1:0]   vec_prop;
  logic [2*DATA_WIDTH-1:0]   vec_exp;

  modport master (
    output vec_valid, vec_inp, vec_par, vec_prop, vec_exp,
    input  vec_ready
  );

  modport slave (
    input  vec_valid, vec_inp, vec_par, vec_prop, vec_exp,
    output vec_ready
  );
endinterface

// File: rtl/cell_test_sequencer.sv
// Self-test controller for one systolic array cell: fetches vectors, loads the parameter,
// drives the operands, waits the cell latency and scores the result.
module cell_test_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_VEC      = 8,
  parameter int CELL_LATENCY = 1,
  localparam int CW = $clog2(NUM_VEC + 1),
  localparam int IW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  cell_test_sequencer_if.slave    vec,
  output logic                    cell_param_load,
  output logic [DATA_WIDTH-1:0]   cell_param,
  output logic [DATA_WIDTH-1:0]   cell_inp,
  output logic [2*DATA_WIDTH-1:0] cell_prop,
  input  logic [2*DATA_WIDTH-1:0] cell_out,
  output logic                    busy,
  output logic                    done,
  output logic [CW-1:0]           pass_cnt,
  output logic [CW-1:0]           fail_cnt,
  output logic [IW-1:0]           first_fail,
  output logic                    mismatch,
  output logic [2:0]              state_dbg
);

  localparam int WW = (CELL_LATENCY > 1) ? $clog2(CELL_LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    APPLY = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0]   inp_q;
  logic [DATA_WIDTH-1:0]   par_q;
  logic [2*DATA_WIDTH-1:0] prop_q;
  logic [2*DATA_WIDTH-1:0] exp_q;
  logic [WW-1:0]           wait_cnt;
  logic [IW-1:0]           vec_idx;
  logic [CW-1:0]           pass_q;
  logic [CW-1:0]           fail_q;
  logic [IW-1:0]           first_q;

  logic last_vec;
  logic start_run;
  logic result_ok;

  assign last_vec  = (vec_idx == IW'(NUM_VEC - 1));
  assign start_run = ((state == IDLE) || (state == DONE)) && start && !abort;
  assign result_ok = (cell_out == exp_q);

  // State register: abort outranks every transition, reset outranks abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (vec.vec_valid) state_next = LOAD;
      LOAD:    state_next = APPLY;
      APPLY:   if (wait_cnt == WW'(CELL_LATENCY - 1)) state_next = CHECK;
      CHECK:   state_next = last_vec ? DONE : FETCH;
      DONE:    if (start) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    vec.vec_ready   = 1'b0;
    cell_param_load = 1'b0;
    cell_inp        = '0;
    cell_prop       = '0;
    busy            = 1'b0;
    done            = 1'b0;
    mismatch        = 1'b0;
    case (state)
      FETCH: begin
        vec.vec_ready = 1'b1;
        busy          = 1'b1;
      end
      LOAD: begin
        cell_param_load = 1'b1;
        busy            = 1'b1;
      end
      APPLY: begin
        cell_inp  = inp_q;
        cell_prop = prop_q;
        busy      = 1'b1;
      end
      CHECK: begin
        cell_inp  = inp_q;
        cell_prop = prop_q;
        busy      = 1'b1;
        mismatch  = !result_ok && !abort;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // par_q doubles as cell_param, so the parameter stays on the bus after LOAD.
  assign cell_param = par_q;
  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  assign first_fail = first_q;
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inp_q    <= '0;
      par_q    <= '0;
      prop_q   <= '0;
      exp_q    <= '0;
      wait_cnt <= '0;
      vec_idx  <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      first_q  <= '0;
    end else begin
      if ((state == FETCH) && vec.vec_valid) begin
        inp_q  <= vec.vec_inp;
        par_q  <= vec.vec_par;
        prop_q <= vec.vec_prop;
        exp_q  <= vec.vec_exp;
      end

      if (state == LOAD) begin
        wait_cnt <= '0;
      end else if (state == APPLY) begin
        wait_cnt <= wait_cnt + WW'(1);
      end

      if (start_run) begin
        pass_q  <= '0;
        fail_q  <= '0;
        first_q <= '0;
        vec_idx <= '0;
      end else if ((state == CHECK) && !abort) begin
        if (result_ok) begin
          pass_q <= pass_q + CW'(1);
        end else begin
          fail_q <= fail_q + CW'(1);
          if (fail_q == '0) first_q <= vec_idx;
        end
        if (!last_vec) vec_idx <= vec_idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cell_test_sequencer.sv
// Directed bench for cell_test_sequencer with behavioural multiply-accumulate cells
// (out = prop + inp*par) of latency 1 (dut_a, 4 vectors) and latency 3 (dut_c, 1 vector).
module tb_cell_test_sequencer;

  localparam int DW = 8;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_LOAD = 3'd2,
                         S_APPLY = 3'd3, S_CHECK = 3'd4, S_DONE = 3'd5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- dut_a: NUM_VEC=4, CELL_LATENCY=1 ----------------
  cell_test_sequencer_if #(.DATA_WIDTH(DW)) vif_a ();
  logic            start_a = 1'b0, abort_a = 1'b0;
  logic            load_a, busy_a, done_a, mm_a;
  logic [DW-1:0]   param_a, inp_a;
  logic [2*DW-1:0] prop_a, out_a;
  logic [2:0]      pass_a, fail_a, st_a;
  logic [1:0]      first_a;

  cell_test_sequencer #(.DATA_WIDTH(DW), .NUM_VEC(4), .CELL_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .vec(vif_a.slave),
    .cell_param_load(load_a), .cell_param(param_a), .cell_inp(inp_a), .cell_prop(prop_a),
    .cell_out(out_a), .busy(busy_a), .done(done_a), .pass_cnt(pass_a), .fail_cnt(fail_a),
    .first_fail(first_a), .mismatch(mm_a), .state_dbg(st_a)
  );

  logic [DW-1:0] cpar_a;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cpar_a <= '0;
      out_a  <= '0;
    end else begin
      if (load_a) cpar_a <= param_a;
      out_a <= 16'(prop_a + 16'(inp_a) * 16'(cpar_a));
    end
  end

  int mm_count_a = 0;
  always @(posedge clk) if (mm_a) mm_count_a <= mm_count_a + 1;

  // ---------------- dut_c: NUM_VEC=1, CELL_LATENCY=3 ----------------
  cell_test_sequencer_if #(.DATA_WIDTH(DW)) vif_c ();
  logic            start_c = 1'b0, abort_c = 1'b0;
  logic            load_c, busy_c, done_c, mm_c;
  logic [DW-1:0]   param_c, inp_c;
  logic [2*DW-1:0] prop_c, out_c;
  logic [0:0]      pass_c, fail_c, first_c;
  logic [2:0]      st_c;

  cell_test_sequencer #(.DATA_WIDTH(DW), .NUM_VEC(1), .CELL_LATENCY(3)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .abort(abort_c), .vec(vif_c.slave),
    .cell_param_load(load_c), .cell_param(param_c), .cell_inp(inp_c), .cell_prop(prop_c),
    .cell_out(out_c), .busy(busy_c), .done(done_c), .pass_cnt(pass_c), .fail_cnt(fail_c),
    .first_fail(first_c), .mismatch(mm_c), .state_dbg(st_c)
  );

  logic [DW-1:0]   cpar_c;
  logic [2*DW-1:0] p1_c, p2_c;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cpar_c <= '0;
      p1_c   <= '0;
      p2_c   <= '0;
      out_c  <= '0;
    end else begin
      if (load_c) cpar_c <= param_c;
      p1_c  <= 16'(prop_c + 16'(inp_c) * 16'(cpar_c));
      p2_c  <= p1_c;
      out_c <= p2_c;
    end
  end

  int load_count_c = 0;
  always @(posedge clk) if (load_c) load_count_c <= load_count_c + 1;

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct {
    logic [DW-1:0]   inp;
    logic [DW-1:0]   par;
    logic [2*DW-1:0] prop;
    logic [2*DW-1:0] exp_val;
    logic            exp_pass;
  } vec_t;

  vec_t tbl[4];
  logic [0:0] exp_q[$];
  int sb_pass = 0, sb_fail = 0, sb_first = 0;

  task automatic drive_a(input int i, input logic valid);
    vif_a.vec_valid = valid;
    vif_a.vec_inp   = tbl[i].inp;
    vif_a.vec_par   = tbl[i].par;
    vif_a.vec_prop  = tbl[i].prop;
    vif_a.vec_exp   = tbl[i].exp_val;
  endtask

  task automatic a_start();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("a_start_state", 32'(st_a), 32'(S_FETCH));
    check("a_start_pass", 32'(pass_a), 0);
    check("a_start_fail", 32'(fail_a), 0);
    check("a_start_busy", 32'(busy_a), 1);
    sb_pass = 0; sb_fail = 0; sb_first = 0;
  endtask

  // Runs one vector from FETCH through CHECK and scores it; leaves the bench just after CHECK.
  task automatic a_vector(input int i);
    logic [0:0] exp_mm;
    drive_a(i, 1'b1);
    check("fetch_ready", 32'(vif_a.vec_ready), 1);
    tick();
    vif_a.vec_valid = 1'b0;
    check("load_state", 32'(st_a), 32'(S_LOAD));
    check("load_pulse", 32'(load_a), 1);
    check("load_param", 32'(param_a), 32'(tbl[i].par));
    check("load_inp_zero", 32'(inp_a), 0);
    tick();
    check("apply_load_low", 32'(load_a), 0);
    check("apply_param_hold", 32'(param_a), 32'(tbl[i].par));
    check("apply_inp", 32'(inp_a), 32'(tbl[i].inp));
    check("apply_prop", 32'(prop_a), 32'(tbl[i].prop));
    tick();
    check("check_state", 32'(st_a), 32'(S_CHECK));
    exp_mm = exp_q.pop_front();
    check("check_mismatch", 32'(mm_a), 32'(exp_mm));
    if (exp_mm == 1'b0) sb_pass++;
    else begin
      if (sb_fail == 0) sb_first = i;
      sb_fail++;
    end
    tick();
    check("cnt_pass", 32'(pass_a), 32'(sb_pass));
    check("cnt_fail", 32'(fail_a), 32'(sb_fail));
    if (sb_fail != 0) check("first_fail", 32'(first_a), 32'(sb_first));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [2:0] c_seq[5];

  initial begin
    // inp*par+prop in 16 bits; vector 2 carries a wrong expectation, vector 3 wraps.
    tbl[0] = '{inp: 8'd5,   par: 8'd3,   prop: 16'd10,    exp_val: 16'd25,    exp_pass: 1'b1};
    tbl[1] = '{inp: 8'd7,   par: 8'd9,   prop: 16'd100,   exp_val: 16'd163,   exp_pass: 1'b1};
    tbl[2] = '{inp: 8'd5,   par: 8'd3,   prop: 16'd10,    exp_val: 16'd0,     exp_pass: 1'b0};
    tbl[3] = '{inp: 8'd255, par: 8'd255, prop: 16'hFFFF,  exp_val: 16'hFE00,  exp_pass: 1'b1};
    c_seq[0] = S_APPLY; c_seq[1] = S_APPLY; c_seq[2] = S_APPLY; c_seq[3] = S_CHECK; c_seq[4] = S_DONE;

    vif_a.vec_valid = 1'b0; vif_a.vec_inp = '0; vif_a.vec_par = '0;
    vif_a.vec_prop = '0; vif_a.vec_exp = '0;
    vif_c.vec_valid = 1'b0; vif_c.vec_inp = '0; vif_c.vec_par = '0;
    vif_c.vec_prop = '0; vif_c.vec_exp = '0;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_state", 32'(st_a), 32'(S_IDLE));
    check("rst_outputs", {busy_a, done_a, load_a, mm_a, vif_a.vec_ready}, 0);
    check("rst_counts", {pass_a, fail_a, first_a}, 0);
    check("rst_cell_bus", {param_a, inp_a, prop_a}, 0);

    // FETCH stall: no handshake, no movement
    a_start();
    for (int k = 0; k < 10; k++) begin
      check("stall_ready", 32'(vif_a.vec_ready), 1);
      check("stall_state", 32'(st_a), 32'(S_FETCH));
      check("stall_load", 32'(load_a), 0);
      tick();
    end

    // Abort during APPLY of vector 1
    exp_q.push_back(1'b0);
    a_vector(0);
    drive_a(1, 1'b1);
    tick();
    vif_a.vec_valid = 1'b0;
    tick();
    check("pre_abort_state", 32'(st_a), 32'(S_APPLY));
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("abort_state", 32'(st_a), 32'(S_IDLE));
    check("abort_inp", 32'(inp_a), 0);
    check("abort_prop", 32'(prop_a), 0);
    check("abort_busy", 32'(busy_a), 0);
    check("abort_keep_pass", 32'(pass_a), 1);
    start_a = 1'b1; abort_a = 1'b1;
    tick();
    start_a = 1'b0; abort_a = 1'b0;
    check("abort_beats_start", 32'(st_a), 32'(S_IDLE));
    a_start();

    // Asynchronous reset in LOAD
    drive_a(1, 1'b1);
    tick();
    vif_a.vec_valid = 1'b0;
    check("pre_reset_load", 32'(load_a), 1);
    #2 reset = 1'b1;
    #1;
    check("async_load_drop", 32'(load_a), 0);
    check("async_state", 32'(st_a), 32'(S_IDLE));
    check("async_param", 32'(param_a), 0);
    check("async_busy", 32'(busy_a), 0);
    #1 reset = 1'b0;
    tick();
    check("post_reset_idle", 32'(st_a), 32'(S_IDLE));

    // start while busy is ignored
    a_start();
    drive_a(0, 1'b1);
    tick();
    vif_a.vec_valid = 1'b0;
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("busy_start_state", 32'(st_a), 32'(S_CHECK));
    tick();
    check("busy_start_next", 32'(st_a), 32'(S_FETCH));
    check("busy_start_pass", 32'(pass_a), 1);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;

    // Table-driven full run, vector 2 mismatches
    for (int i = 0; i < 4; i++) exp_q.push_back(tbl[i].exp_pass ? 1'b0 : 1'b1);
    a_start();
    mm_count_a = 0;
    for (int i = 0; i < 4; i++) a_vector(i);
    check("run_done", 32'(done_a), 1);
    check("run_busy", 32'(busy_a), 0);
    check("run_state", 32'(st_a), 32'(S_DONE));
    check("run_pass", 32'(pass_a), 3);
    check("run_fail", 32'(fail_a), 1);
    check("run_first_fail", 32'(first_a), 2);
    check("run_total", 32'(pass_a) + 32'(fail_a), 4);
    check("run_mm_pulses", 32'(mm_count_a), 1);
    tick();
    check("done_holds", 32'(st_a), 32'(S_DONE));
    a_start();

    // Latency-3 cell, one vector
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    check("c_fetch", 32'(st_c), 32'(S_FETCH));
    vif_c.vec_valid = 1'b1; vif_c.vec_inp = 8'd5; vif_c.vec_par = 8'd3;
    vif_c.vec_prop = 16'd10; vif_c.vec_exp = 16'd25;
    tick();
    vif_c.vec_valid = 1'b0;
    check("c_load", 32'(st_c), 32'(S_LOAD));
    check("c_load_param", 32'(param_c), 3);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("c_seq", 32'(st_c), 32'(c_seq[k]));
      if (c_seq[k] == S_APPLY) check("c_apply_inp", 32'(inp_c), 5);
      if (c_seq[k] == S_CHECK) begin
        check("c_cell_out", 32'(out_c), 25);
        check("c_mismatch", 32'(mm_c), 0);
      end
    end
    check("c_done", 32'(done_c), 1);
    check("c_pass", 32'(pass_c), 1);
    check("c_fail", 32'(fail_c), 0);
    check("c_load_pulses", 32'(load_count_c), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
